// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - scan FSM state encoding, deadtime length and dwell-length helper.
package scan_pkg;

    localparam int DEADTIME_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_BLANK,
        ST_LATCH,
`ifdef SCAN_DEADTIME_EN
        ST_DEADTIME,
`endif
        ST_DISPLAY
    } scan_state_t;

    // Binary-weighted OE-low time: plane n stays lit base * 2^n cycles.
    function automatic int unsigned dwell_cycles(input int unsigned base, input int unsigned plane);
        return base << plane;
    endfunction

endpackage

// File: rtl/scan_dwell_timer.sv
// rtl/scan_dwell_timer.sv - loadable down-counter; done marks the last cycle of a timed state.
module scan_dwell_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == WIDTH'(1));

endmodule

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - HUB75 column/row/bitplane scan FSM; define SCAN_DEADTIME_EN for OE deadtime after latch.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int PIXEL_WIDTH       = 64,
    parameter int PIXEL_HALFHEIGHT  = 16,
    parameter int BRIGHTNESS_LEVELS = 6,
    parameter int LOAD_CYCLES       = 4,
    parameter int DISPLAY_BASE      = 8
) (
    input  logic                                 clk_in,
    input  logic                                 reset,
    input  logic                                 enable,
    output logic [$clog2(PIXEL_WIDTH)-1:0]       column_address,
    output logic [$clog2(PIXEL_HALFHEIGHT)-1:0]  row_address,
    output logic [$clog2(BRIGHTNESS_LEVELS)-1:0] bitplane,
    output logic                                 pixel_load_start,
    output logic                                 pixel_clock,
    output logic                                 row_latch,
    output logic                                 output_enable_n,
    output logic                                 frame_start
);

    localparam int CW = $clog2(PIXEL_WIDTH);
    localparam int RW = $clog2(PIXEL_HALFHEIGHT);
    localparam int PW = $clog2(BRIGHTNESS_LEVELS);
    localparam int DW = $clog2(DISPLAY_BASE << (BRIGHTNESS_LEVELS - 1)) + 1;

    localparam logic [CW-1:0] COL_LAST   = CW'(PIXEL_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(PIXEL_HALFHEIGHT - 1);
    localparam logic [PW-1:0] PLANE_LAST = PW'(BRIGHTNESS_LEVELS - 1);
    localparam logic [DW-1:0] LOAD_LEN   = DW'(LOAD_CYCLES);

    scan_state_t   state, state_next;
    logic [CW-1:0] col_next;
    logic [RW-1:0] row_next;
    logic [PW-1:0] plane_next;
    logic          timer_load;
    logic [DW-1:0] timer_value;
    logic          timer_done;
    logic [DW-1:0] dwell_len;
    logic          entering_load;

    assign dwell_len = DW'(dwell_cycles(DISPLAY_BASE, 32'(bitplane)));

    scan_dwell_timer #(.WIDTH(DW)) u_dwell_timer (
        .clk_in     (clk_in),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

    always_comb begin
        state_next  = state;
        col_next    = column_address;
        row_next    = row_address;
        plane_next  = bitplane;
        timer_load  = 1'b0;
        timer_value = LOAD_LEN;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_next = ST_LOAD;
                    timer_load = 1'b1;
                end
            end
            ST_LOAD: begin
                if (timer_done) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (column_address != COL_LAST) begin
                    col_next   = column_address + CW'(1);
                    state_next = ST_LOAD;
                    timer_load = 1'b1;
                end else begin
                    col_next   = '0;
                    state_next = ST_BLANK;
                end
            end
            ST_BLANK: state_next = ST_LATCH;
            ST_LATCH: begin
                timer_load = 1'b1;
`ifdef SCAN_DEADTIME_EN
                state_next  = ST_DEADTIME;
                timer_value = DW'(DEADTIME_CYCLES);
`else
                state_next  = ST_DISPLAY;
                timer_value = dwell_len;
`endif
            end
`ifdef SCAN_DEADTIME_EN
            ST_DEADTIME: begin
                if (timer_done) begin
                    state_next  = ST_DISPLAY;
                    timer_load  = 1'b1;
                    timer_value = dwell_len;
                end
            end
`endif
            ST_DISPLAY: begin
                // enable only matters here, so a row or dwell is never cut short
                if (timer_done) begin
                    if (bitplane == PLANE_LAST) begin
                        plane_next = '0;
                        row_next   = (row_address == ROW_LAST) ? '0 : row_address + RW'(1);
                    end else begin
                        plane_next = bitplane + PW'(1);
                    end
                    if (enable) begin
                        state_next = ST_LOAD;
                        timer_load = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign entering_load = (state_next == ST_LOAD) && (state != ST_LOAD);

    // Strobes are registered from the next state so they line up with it.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            column_address   <= '0;
            row_address      <= '0;
            bitplane         <= '0;
            pixel_load_start <= 1'b0;
            pixel_clock      <= 1'b0;
            row_latch        <= 1'b0;
            output_enable_n  <= 1'b1;
            frame_start      <= 1'b0;
        end else begin
            state            <= state_next;
            column_address   <= col_next;
            row_address      <= row_next;
            bitplane         <= plane_next;
            pixel_load_start <= entering_load;
            frame_start      <= entering_load && (col_next == '0) && (row_next == '0) && (plane_next == '0);
            pixel_clock      <= (state_next == ST_SHIFT);
            row_latch        <= (state_next == ST_LATCH);
            output_enable_n  <= (state_next != ST_DISPLAY);
        end
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - scoreboard bench for scan_sequencer timing, resume and reset behaviour.
module tb_scan_sequencer;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int B    = 2;
    localparam int L    = 4;
    localparam int BASE = 8;
`ifdef SCAN_DEADTIME_EN
    localparam int DT = 2;
`else
    localparam int DT = 0;
`endif

    logic       clk_in = 1'b0;
    logic       reset  = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] column_address;
    logic [0:0] row_address;
    logic [0:0] bitplane;
    logic       pixel_load_start;
    logic       pixel_clock;
    logic       row_latch;
    logic       output_enable_n;
    logic       frame_start;

    scan_sequencer #(
        .PIXEL_WIDTH       (W),
        .PIXEL_HALFHEIGHT  (H),
        .BRIGHTNESS_LEVELS (B),
        .LOAD_CYCLES       (L),
        .DISPLAY_BASE      (BASE)
    ) dut (
        .clk_in           (clk_in),
        .reset            (reset),
        .enable           (enable),
        .column_address   (column_address),
        .row_address      (row_address),
        .bitplane         (bitplane),
        .pixel_load_start (pixel_load_start),
        .pixel_clock      (pixel_clock),
        .row_latch        (row_latch),
        .output_enable_n  (output_enable_n),
        .frame_start      (frame_start)
    );

    always #5 clk_in = ~clk_in;

    // kind: 0 load, 1 pixel clock, 2 latch, 3 OE window (col = length), 4 stray frame_start
    typedef struct {
        int kind;
        int cyc;
        int col;
        int row;
        int plane;
        int fs;
    } ev_t;

    ev_t exp_q[$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  pcount      = 0;
    bit  mon_en      = 1'b1;
    bit  oe_open     = 1'b0;
    int  oe_start    = 0;

    always @(posedge clk_in or posedge reset) begin
        if (reset) pcount <= 0;
        else       pcount <= pcount + 1;
    end

    always @(negedge clk_in) begin : monitor
        ev_t o;
        ev_t e;
        ev_t obs[$];
        if (reset || !mon_en) begin
            oe_open = 1'b0;
        end else begin
            if (oe_open && output_enable_n) begin
                oe_open = 1'b0;
                obs.push_back('{3, oe_start, pcount - oe_start, 0, 0, 0});
            end else if (!oe_open && !output_enable_n) begin
                oe_open  = 1'b1;
                oe_start = pcount;
            end
            if (pixel_load_start)
                obs.push_back('{0, pcount, int'(column_address), int'(row_address), int'(bitplane), int'(frame_start)});
            else if (frame_start)
                obs.push_back('{4, pcount, 0, 0, 0, 1});
            if (pixel_clock)
                obs.push_back('{1, pcount, int'(column_address), int'(row_address), int'(bitplane), 0});
            if (row_latch)
                obs.push_back('{2, pcount, int'(column_address), int'(row_address), int'(bitplane), 0});
            while (obs.size() > 0) begin
                o = obs.pop_front();
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_event: got kind=%0d cyc=%0d col=%0d row=%0d plane=%0d fs=%0d, required no event",
                             o.kind, o.cyc, o.col, o.row, o.plane, o.fs);
                end else begin
                    e = exp_q.pop_front();
                    if (o.kind !== e.kind || o.cyc !== e.cyc || o.col !== e.col ||
                        o.row !== e.row || o.plane !== e.plane || o.fs !== e.fs) begin
                        miscompares++;
                        $display("FAIL event: got kind=%0d cyc=%0d col=%0d row=%0d plane=%0d fs=%0d, required kind=%0d cyc=%0d col=%0d row=%0d plane=%0d fs=%0d",
                                 o.kind, o.cyc, o.col, o.row, o.plane, o.fs,
                                 e.kind, e.cyc, e.col, e.row, e.plane, e.fs);
                    end
                end
            end
        end
    end

    // Expected events of one row-plane whose first LOAD cycle is s.
    task automatic push_rowplane(input int s, input int row, input int plane, output int nxt);
        int t;
        int ds;
        int dwell;
        for (int k = 0; k < W; k++) begin
            exp_q.push_back('{0, s + k * (L + 1), k, row, plane, (k == 0 && row == 0 && plane == 0) ? 1 : 0});
            exp_q.push_back('{1, s + k * (L + 1) + L, k, row, plane, 0});
        end
        t     = s + W * (L + 1);
        exp_q.push_back('{2, t + 1, 0, row, plane, 0});
        dwell = BASE << plane;
        ds    = t + 2 + DT;
        exp_q.push_back('{3, ds, dwell, 0, 0, 0});
        nxt   = ds + dwell;
    endtask

    // Run n row-planes back to back, dropping enable in the SHIFT of the last one.
    task automatic run_burst(input int n, input int row0, input int plane0, input bit from_reset);
        int s;
        int nxt;
        int last_s;
        int r;
        int p;
        int guard;
        r = row0;
        p = plane0;
        @(negedge clk_in);
        #1;
        s      = pcount + 1;
        last_s = s;
        for (int i = 0; i < n; i++) begin
            last_s = s;
            push_rowplane(s, r, p, nxt);
            s = nxt;
            if (p == B - 1) begin
                p = 0;
                r = (r == H - 1) ? 0 : r + 1;
            end else begin
                p = p + 1;
            end
        end
        enable = 1'b1;
        if (from_reset) reset = 1'b0;
        guard = 0;
        while (pcount < last_s + L && guard < 2000) begin
            @(negedge clk_in);
            guard++;
        end
        #1 enable = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(negedge clk_in);
            guard++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL burst_drain row=%0d plane=%0d: %0d events pending, required 0", row0, plane0, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk_in);
        vectors += 4;
        if (output_enable_n !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_oe_n: got %b, required 1", output_enable_n);
        end
        if ({pixel_load_start, pixel_clock, row_latch, frame_start} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b, required 0000", {pixel_load_start, pixel_clock, row_latch, frame_start});
        end
        if (column_address !== 2'd0 || row_address !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_addr: got col=%0d row=%0d, required 0 0", column_address, row_address);
        end
        if (bitplane !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_plane: got %0d, required 0", bitplane);
        end
    endtask

    task automatic test_idle_hold(input int row, input int plane);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_in);
            vectors++;
            if ({output_enable_n, pixel_load_start, pixel_clock, row_latch} !== 4'b1000) begin
                miscompares++;
                $display("FAIL idle_strobes: got oe_n/load/pclk/lat=%b, required 1000", {output_enable_n, pixel_load_start, pixel_clock, row_latch});
            end
        end
        vectors++;
        if (int'(row_address) !== row || int'(bitplane) !== plane || column_address !== 2'd0) begin
            miscompares++;
            $display("FAIL idle_hold: got col=%0d row=%0d plane=%0d, required col=0 row=%0d plane=%0d",
                     column_address, row_address, bitplane, row, plane);
        end
    endtask

    task automatic test_reset_mid_display();
        int guard;
        @(negedge clk_in);
        #1;
        mon_en = 1'b0;
        enable = 1'b1;
        guard  = 0;
        while (output_enable_n !== 1'b0 && guard < 500) begin
            @(negedge clk_in);
            guard++;
        end
        vectors++;
        if (output_enable_n !== 1'b0 || bitplane !== 1'b1) begin
            miscompares++;
            $display("FAIL reach_display: got oe_n=%b plane=%0d, required 0 1", output_enable_n, bitplane);
        end
        repeat (3) @(negedge clk_in);
        #1 reset = 1'b1;
        #1;
        vectors += 3;
        if (output_enable_n !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset_oe_n: got %b, required 1", output_enable_n);
        end
        if (column_address !== 2'd0 || row_address !== 1'b0 || bitplane !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_counters: got col=%0d row=%0d plane=%0d, required 0 0 0", column_address, row_address, bitplane);
        end
        if ({pixel_load_start, pixel_clock, row_latch, frame_start} !== 4'b0000) begin
            miscompares++;
            $display("FAIL async_reset_strobes: got %b, required 0000", {pixel_load_start, pixel_clock, row_latch, frame_start});
        end
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        run_burst(5, 0, 0, 1'b1);
        test_idle_hold(0, 1);
        run_burst(1, 0, 1, 1'b0);
        test_idle_hold(1, 0);
        run_burst(2, 1, 0, 1'b0);
        test_idle_hold(0, 0);
        run_burst(1, 0, 0, 1'b0);
        test_reset_mid_display();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
